// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the SEQ fetch stage.
// Contents: instruction-code constants (IHALT..IPOPQ), the "no register"
// marker NREG, the stat encoding, bus widths, and the fetch FSM state type.
package fetch_unit_pkg;

  localparam int DATA_BUS     = 64;
  localparam int ICODE_BUS    = 4;
  localparam int REG_ADDR_BUS = 4;

  localparam logic [ICODE_BUS-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_BUS-1:0] INOP    = 4'h1;
  localparam logic [ICODE_BUS-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_BUS-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_BUS-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_BUS-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_BUS-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_BUS-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_BUS-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_BUS-1:0] IRET    = 4'h9;
  localparam logic [ICODE_BUS-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_BUS-1:0] IPOPQ   = 4'hB;

  localparam logic [REG_ADDR_BUS-1:0] NREG = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational instruction splitter for the fetch stage.
// Ports:
//   window_i  80-bit instruction window, byte0 = [7:0] (little-endian)
//   pc_i      address of byte0
//   icode_o, ifun_o, ra_o, rb_o, valc_o  extracted fields (NREG when no regids)
//   valp_o    pc_i + instruction length, wrapping modulo 2^64
//   stat_o    AOK / HLT / INS for this window (ADR is decided by the caller)
module fetch_predecode
  import fetch_unit_pkg::*;
(
  input  logic [79:0]             window_i,
  input  logic [DATA_BUS-1:0]     pc_i,
  output logic [ICODE_BUS-1:0]    icode_o,
  output logic [3:0]              ifun_o,
  output logic [REG_ADDR_BUS-1:0] ra_o,
  output logic [REG_ADDR_BUS-1:0] rb_o,
  output logic [DATA_BUS-1:0]     valc_o,
  output logic [DATA_BUS-1:0]     valp_o,
  output stat_e                   stat_o
);

  logic       need_regids;
  logic       need_valc;
  logic [3:0] length;

  assign icode_o = window_i[7:4];
  assign ifun_o  = window_i[3:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    need_regids = 1'b0;
    need_valc   = 1'b0;
    length      = 4'd1;
    case (icode_o)
      IHALT, INOP, IRET:            length = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        need_regids = 1'b1;
        length      = 4'd2;
      end
      IJXX, ICALL: begin
        need_valc = 1'b1;
        length    = 4'd9;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
        length      = 4'd10;
      end
      default: length = 4'd1;
    endcase
  end

  assign ra_o = need_regids ? window_i[15:12] : NREG;
  assign rb_o = need_regids ? window_i[11:8]  : NREG;

  // The constant follows the register byte when there is one.
  assign valc_o = !need_valc  ? '0 :
                  need_regids ? window_i[79:16] : window_i[71:8];

  assign valp_o = pc_i + DATA_BUS'(length);

  always_comb begin
    stat_o = STAT_AOK;
    if (icode_o > IPOPQ) begin
      stat_o = STAT_INS;
    end else if (icode_o == IOPQ) begin
      if (ifun_o > 4'd3) stat_o = STAT_INS;
    end else if (icode_o == IRRMOVQ || icode_o == IJXX) begin
      if (ifun_o > 4'd6) stat_o = STAT_INS;
    end else if (ifun_o != 4'd0) begin
      stat_o = STAT_INS;
    end else if (icode_o == IHALT) begin
      stat_o = STAT_HLT;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// SEQ fetch stage: holds the PC, requests a 10-byte window from instruction
// memory, registers the split instruction for decode and waits for commit.
// Optional feature macro: FETCH_WDT_EN (fetch watchdog of WDT_CYCLES cycles;
// a timeout reports ADR and the unit halts after that instruction commits).
// Ports:
//   clk_i, rst_i (async, active-low)
//   imem_req_o/imem_addr_o/imem_valid_i/imem_data_i/imem_err_i  memory side
//   icode_o..valP_o, instr_valid_o, stat_o                       decode side
//   commit_i/next_pc_i                                           retire strobe
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          WDT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [79:0] imem_data_i,
  input  logic        imem_err_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_valid_o,
  output logic [2:0]  stat_o,
  input  logic        commit_i,
  input  logic [63:0] next_pc_i
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q;
  stat_e        stat_q;

  logic [3:0]   pd_icode, pd_ifun, pd_ra, pd_rb;
  logic [63:0]  pd_valc, pd_valp;
  stat_e        pd_stat;

  logic         rsp_ok;     // good window accepted this cycle
  logic         fault;      // memory error or watchdog timeout this cycle
  logic         wdt_expire;
  logic         retire;

  fetch_predecode u_predecode (
    .window_i (imem_data_i),
    .pc_i     (pc_q),
    .icode_o  (pd_icode),
    .ifun_o   (pd_ifun),
    .ra_o     (pd_ra),
    .rb_o     (pd_rb),
    .valc_o   (pd_valc),
    .valp_o   (pd_valp),
    .stat_o   (pd_stat)
  );

`ifdef FETCH_WDT_EN
  logic [7:0] wdt_cnt_q;

  // Counts consecutive FETCH cycles without a response; held at zero
  // elsewhere, so it is already clear on every entry to FETCH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdt_cnt_q <= '0;
    end else if (state_q == S_FETCH && !imem_valid_i) begin
      wdt_cnt_q <= wdt_cnt_q + 8'd1;
    end else begin
      wdt_cnt_q <= '0;
    end
  end

  // A response in the timeout cycle wins over the timeout.
  assign wdt_expire = (state_q == S_FETCH) && !imem_valid_i &&
                      (wdt_cnt_q == 8'(WDT_CYCLES - 1));
`else
  logic [31:0] unused_wdt_cycles;
  assign unused_wdt_cycles = 32'(WDT_CYCLES);
  assign wdt_expire        = 1'b0;
`endif

  assign rsp_ok = (state_q == S_FETCH) && imem_valid_i && !imem_err_i;
  assign fault  = ((state_q == S_FETCH) && imem_valid_i && imem_err_i) || wdt_expire;
  assign retire = (state_q == S_ISSUE) && commit_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: all registers use non-blocking assignment so each one samples
      // pre-edge values regardless of statement order.
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (rsp_ok || fault) state_d = S_ISSUE;
      S_ISSUE: if (commit_i) state_d = (stat_q == STAT_AOK) ? S_FETCH : S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      icode_o       <= INOP;
      ifun_o        <= 4'h0;
      rA_o          <= NREG;
      rB_o          <= NREG;
      valC_o        <= '0;
      valP_o        <= '0;
      instr_valid_o <= 1'b0;
      stat_q        <= STAT_AOK;
    end else if (rsp_ok) begin
      icode_o       <= pd_icode;
      ifun_o        <= pd_ifun;
      rA_o          <= pd_ra;
      rB_o          <= pd_rb;
      valC_o        <= pd_valc;
      valP_o        <= pd_valp;
      instr_valid_o <= 1'b1;
      stat_q        <= pd_stat;
    end else if (fault) begin
      // Presented to decode as a NOP that makes no progress.
      icode_o       <= INOP;
      ifun_o        <= 4'h0;
      rA_o          <= NREG;
      rB_o          <= NREG;
      valC_o        <= '0;
      valP_o        <= pc_q;
      instr_valid_o <= 1'b1;
      stat_q        <= STAT_ADR;
    end else if (retire) begin
      pc_q          <= next_pc_i;
      instr_valid_o <= 1'b0;
    end
  end

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign stat_o      = stat_q;

endmodule
